// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES controller poller: button bit positions,
// sequencer states and default timing.
package nes_pad_pkg;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // 6 us half-period and 60 Hz poll rate at a 50 MHz system clock
   localparam int CLK_DIV_DEFAULT     = 300;
   localparam int POLL_PERIOD_DEFAULT = 833333;

   localparam int PHASE_W = 12;
   localparam int TIMER_W = 20;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      GAP,
      CLKHI,
      CLKLO,
      DONE
   } pad_state_t;

   function automatic logic [7:0] rising_mask(input logic [7:0] now, input logic [7:0] prev);
      return now & ~prev;
   endfunction

endpackage

// File: rtl/nes_pad_tick.sv
// Free-running poll-period counter; tick is high for the single cycle in which
// the counter sits at PERIOD-1 and is about to wrap to zero.
module nes_pad_tick #(
   parameter int PERIOD = 833333,
   parameter int W      = 20
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/nes_pad_poller.sv
// Autonomous NES pad reader: latch pulse, eight shift clocks, registered button byte
// and newly-pressed mask. Optional interrupt is built when NES_PAD_IRQ_EN is defined.
module nes_pad_poller
   import nes_pad_pkg::*;
#(
   parameter int CLK_DIV     = CLK_DIV_DEFAULT,
   parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       NES_data,
   output logic       NES_latch,
   output logic       NES_clk,
   output logic       busy,
   output logic       valid,
   output logic [7:0] buttons,
   output logic [7:0] pressed,
   input  logic       irq_ack,
   output logic       irq
);

   localparam logic [PHASE_W-1:0] DIV_M1 = PHASE_W'(CLK_DIV - 1);

   pad_state_t         state, state_n;
   logic [PHASE_W-1:0] phase, phase_n;
   logic               half, half_n;
   logic [2:0]         bit_idx, bit_idx_n;
   logic [7:0]         shreg;
   logic [7:0]         sample_byte;
   logic [7:0]         new_pressed;
   logic               tick;
   logic               trigger;
   logic               phase_done;
   logic               sample;
   logic               seq_end;

   nes_pad_tick #(
      .PERIOD (POLL_PERIOD),
      .W      (TIMER_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign trigger    = start | tick;
   assign phase_done = (phase == '0);

   // Byte as it will look once the bit being sampled this cycle is written
   always_comb begin
      sample_byte          = shreg;
      sample_byte[bit_idx] = ~NES_data;
   end

   assign new_pressed = rising_mask(sample_byte, buttons);

   always_comb begin
      state_n   = state;
      phase_n   = phase - PHASE_W'(1);
      half_n    = half;
      bit_idx_n = bit_idx;
      sample    = 1'b0;
      seq_end   = 1'b0;
      case (state)
         IDLE: begin
            phase_n = phase;
            if (trigger) begin
               state_n = LATCH;
               phase_n = DIV_M1;
               half_n  = 1'b0;
            end
         end
         LATCH: begin
            // 2*CLK_DIV can exceed the 12-bit phase range, so count two halves
            if (phase_done) begin
               phase_n = DIV_M1;
               if (!half) begin
                  half_n = 1'b1;
               end else begin
                  half_n  = 1'b0;
                  state_n = GAP;
               end
            end
         end
         GAP: begin
            if (phase_done) begin
               sample    = 1'b1;
               bit_idx_n = bit_idx + 3'd1;
               phase_n   = DIV_M1;
               state_n   = CLKHI;
            end
         end
         CLKHI: begin
            if (phase_done) begin
               phase_n = DIV_M1;
               state_n = CLKLO;
            end
         end
         CLKLO: begin
            if (phase_done) begin
               sample  = 1'b1;
               phase_n = DIV_M1;
               if (bit_idx == 3'd7) begin
                  bit_idx_n = 3'd0;
                  seq_end   = 1'b1;
                  state_n   = DONE;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  state_n   = CLKHI;
               end
            end
         end
         DONE: begin
            phase_n = '0;
            state_n = IDLE;
         end
         default: begin
            phase_n = '0;
            state_n = IDLE;
         end
      endcase
   end

   // Pad pins and status flags are decoded from the next state so they are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= '0;
         half      <= 1'b0;
         bit_idx   <= 3'd0;
         NES_latch <= 1'b0;
         NES_clk   <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         buttons   <= 8'h00;
         pressed   <= 8'h00;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         half      <= half_n;
         bit_idx   <= bit_idx_n;
         NES_latch <= (state_n == LATCH);
         NES_clk   <= (state_n == CLKHI);
         busy      <= (state_n != IDLE);
         valid     <= seq_end;
         if (seq_end) begin
            buttons <= sample_byte;
            pressed <= new_pressed;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sample) begin
         shreg <= sample_byte;
      end
   end

`ifdef NES_PAD_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
      end else if (seq_end && (new_pressed != 8'h00)) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
// Scoreboard bench for nes_pad_poller with CLK_DIV=4, POLL_PERIOD=200 and a 4021-style pad model.
`timescale 1ns/1ps
module tb_nes_pad_poller;

   localparam int DIV = 4;
   localparam int PER = 200;
   localparam int SEQ = 17 * DIV + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       irq_ack = 1'b0;
   logic       NES_data;
   logic       NES_latch, NES_clk, busy, valid, irq;
   logic [7:0] buttons, pressed;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rel0 = 0;
   int valid_cnt = 0;

   logic [7:0] pad_line = 8'hFF;
   logic [7:0] pad_sh = 8'hFF;
   logic       pad_clk_d = 1'b0;

   typedef struct {
      int         t;
      logic [7:0] b;
      logic [7:0] p;
      logic       i;
   } exp_t;
   exp_t sb[$];

   nes_pad_poller #(
      .CLK_DIV     (DIV),
      .POLL_PERIOD (PER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .NES_data  (NES_data),
      .NES_latch (NES_latch),
      .NES_clk   (NES_clk),
      .busy      (busy),
      .valid     (valid),
      .buttons   (buttons),
      .pressed   (pressed),
      .irq_ack   (irq_ack),
      .irq       (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pad: parallel load while latched, shift on each rising NES_clk, ones shifted in
   always @(negedge clk) begin
      if (NES_latch) pad_sh <= pad_line;
      else if (NES_clk && !pad_clk_d) pad_sh <= {1'b1, pad_sh[7:1]};
      pad_clk_d <= NES_clk;
   end
   assign NES_data = pad_sh[0];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, cyc - rel0);
      end
   endtask

   function automatic logic irq_exp(input logic v);
`ifdef NES_PAD_IRQ_EN
      return v;
`else
      return 1'b0 & v;
`endif
   endfunction

   task automatic expect_poll(input int t, input logic [7:0] b, input logic [7:0] p, input logic i);
      exp_t e;
      e.t = t; e.b = b; e.p = p; e.i = irq_exp(i);
      sb.push_back(e);
   endtask

   task automatic wait_to(input int t);
      while (cyc - rel0 < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic neg_at(input int t);
      wait_to(t);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst) check("latch_clk_overlap", int'(NES_latch & NES_clk), 0);
      if (valid) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            check("valid_unexpected", int'(valid), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("valid_time", cyc - rel0, e.t);
            check("buttons", int'(buttons), int'(e.b));
            check("pressed", int'(pressed), int'(e.p));
            check("irq_at_valid", int'(irq), int'(e.i));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end, got t=%0d", cyc - rel0);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_latch", int'(NES_latch), 0);
      check("rst_clk", int'(NES_clk), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_buttons", int'(buttons), 0);
      check("rst_pressed", int'(pressed), 0);
      check("rst_irq", int'(irq), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rel0 = cyc;

      // Poll 1: even buttons pressed, start pulse at t=2
      wait_to(2);
      pad_line = 8'hAA;
      start = 1'b1;
      expect_poll(2 + SEQ, 8'h55, 8'h55, 1'b1);
      @(negedge clk);
      check("p1_latch_before", int'(NES_latch), 0);
      check("p1_busy_before", int'(busy), 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("p1_latch_first", int'(NES_latch), 1);
      check("p1_busy_first", int'(busy), 1);
      neg_at(10);
      check("p1_latch_last", int'(NES_latch), 1);
      neg_at(11);
      check("p1_latch_off", int'(NES_latch), 0);
      neg_at(14);
      check("p1_clk_gap", int'(NES_clk), 0);
      neg_at(15);
      check("p1_clk_first", int'(NES_clk), 1);
      neg_at(71);
      check("p1_busy_done", int'(busy), 1);
      neg_at(72);
      check("p1_busy_fall", int'(busy), 0);
      neg_at(79);
      check("p1_irq_held", int'(irq), int'(irq_exp(1'b1)));
      wait_to(80);
      irq_ack = 1'b1;
      @(posedge clk); #1;
      irq_ack = 1'b0;
      @(negedge clk);
      check("p1_irq_acked", int'(irq), 0);

      // Poll 2: A released as well, nothing newly pressed
      wait_to(90);
      pad_line = 8'hAB;
      start = 1'b1;
      expect_poll(90 + SEQ, 8'h54, 8'h00, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      neg_at(160);
      check("p2_busy_fall", int'(busy), 0);

      // Poll 3: triggered by the timer tick at t=199; ack coincides with irq set
      wait_to(170);
      pad_line = 8'hFE;
      expect_poll(199 + SEQ, 8'h01, 8'h01, 1'b1);
      neg_at(199);
      check("p3_busy_pre_tick", int'(busy), 0);
      neg_at(200);
      check("p3_busy_tick", int'(busy), 1);
      check("p3_latch_tick", int'(NES_latch), 1);
      wait_to(267);
      irq_ack = 1'b1;
      @(posedge clk); #1;
      irq_ack = 1'b0;
      neg_at(275);
      check("p3_irq_hold", int'(irq), int'(irq_exp(1'b1)));
      wait_to(280);
      irq_ack = 1'b1;
      @(posedge clk); #1;
      irq_ack = 1'b0;
      @(negedge clk);
      check("p3_irq_acked", int'(irq), 0);

      // Poll 4: unplugged pad, start in the same cycle as the t=399 tick
      wait_to(300);
      pad_line = 8'hFF;
      wait_to(399);
      start = 1'b1;
      expect_poll(399 + SEQ, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      neg_at(470);
      check("p4_valid_count", valid_cnt, 4);
      check("p4_sb_empty", sb.size(), 0);

      // start held high: polls every 70 cycles, tick at t=599 falls inside a poll
      wait_to(480);
      pad_line = 8'hAA;
      start = 1'b1;
      expect_poll(480 + SEQ, 8'h55, 8'h55, 1'b1);
      expect_poll(550 + SEQ, 8'h55, 8'h00, 1'b1);
      expect_poll(620 + SEQ, 8'h55, 8'h00, 1'b1);
      expect_poll(690 + SEQ, 8'h55, 8'h00, 1'b1);
      neg_at(550);
      check("held_idle_gap", int'(busy), 0);
      neg_at(551);
      check("held_restart", int'(busy), 1);
      wait_to(700);
      start = 1'b0;

      // Reset during CLKHI of bit 3 aborts with no update
      wait_to(770);
      pad_line = 8'h00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      neg_at(800);
      check("abort_clkhi", int'(NES_clk), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_latch", int'(NES_latch), 0);
      check("abort_clk", int'(NES_clk), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_buttons", int'(buttons), 0);
      check("abort_pressed", int'(pressed), 0);
      check("abort_irq", int'(irq), 0);
      neg_at(900);
      check("final_valid_count", valid_cnt, 8);
      check("final_sb_empty", sb.size(), 0);
      check("final_buttons", int'(buttons), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
